rv32i_mc_control: RTL and testbench
===================================

Name: rv32i_mc_control

Overview:
- Multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle main_control with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles.
- It talks to a shared instruction/data memory through a req/ready handshake that tolerates variable wait states.
- It adds a memory-timeout trap, an illegal-instruction trap, and parametrised cycle/instret performance counters.
- It sits between the multi-cycle data_path and the unified memory port.

Parameters:
- CNT_W, 32, width of cycle_count and instret_count (wrap on overflow).
- MEM_TIMEOUT, 16, maximum cycles mem_req may stay unanswered before trapping (>=1).
- RESET_TO_FETCH, 1, 1 = leave reset directly into S_FETCH; 0 = idle in S_HALT until start is high.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leaves S_HALT when RESET_TO_FETCH=0
- opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  1  IR[30]
- zero  in  1  ALU result == 0
- less  in  1  signed rs1 < rs2
- less_u  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- addr_sel  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR (ALU & ~1)
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
- alu_ctrl  out  4  ALU operation (alu_op_t)
- reg_write  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 = none, 1 = illegal, 2 = mem timeout
- cycle_count  out  CNT_W  cycles since reset, excluding S_HALT
- instret_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, active-high):
  - State goes to S_FETCH, or to S_HALT when RESET_TO_FETCH=0.
  - Counters, the wait counter, trap and trap_cause all clear to 0.
  - All strobes are 0; every mux select is 0.
  - Reset mid-request drops mem_req immediately; no retirement is counted.
- Outputs are Moore, decoded from state plus the latched opcode. Exceptions: ir_write, pc_write, reg_write and instret_count increments are qualified by mem_ready where they are tied to memory.
- S_FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1; pc_write=1 with pc_sel=0 (ALU computes PC+4 using src_a=1, src_b=2, ADD); go to S_DECODE.
- S_DECODE: ALU computes PC+imm (branch target precompute, latched by data_path). Next state by opcode:
  - 0110011 goes to S_EXEC_R.
  - 0010011 goes to S_EXEC_I.
  - 0000011 and 0100011 go to S_ADDR.
  - 1100011 goes to S_BRANCH.
  - 1101111 goes to S_JAL.
  - 1100111 goes to S_JALR.
  - 0110111 and 0010111 go to S_UPPER.
  - Any other opcode goes to S_TRAP with cause 1.
- S_EXEC_R / S_EXEC_I:
  - alu_ctrl is decoded from func3/func7.
  - func7 only selects SUB for R-type and SRA for both types; it is ignored for I-type ADDI.
  - Next state S_WB_ALU.
- S_ADDR: ADD rs1+imm, then go to S_MEM_RD for loads and S_MEM_WR for stores.
- S_MEM_RD: mem_req=1, addr_sel=1; on mem_ready go to S_WB_MEM.
- S_MEM_WR: mem_req=1, mem_we=1, addr_sel=1; on mem_ready retire and go to S_FETCH.
- S_WB_ALU / S_WB_MEM: reg_write=1 with wb_sel 0 or 1 respectively; retire; go to S_FETCH.
- S_BRANCH: SUB rs1-rs2. Taken conditions:
  - BEQ: zero.
  - BNE: !zero.
  - BLT: less.
  - BGE: !less.
  - BLTU: less_u.
  - BGEU: !less_u.
  - func3 010 or 011 goes to S_TRAP with cause 1.
  - When taken: pc_write=1, pc_sel=1.
  - Retire; go to S_FETCH.
- S_JAL: pc_write=1, pc_sel=1, reg_write=1, wb_sel=2; retire.
- S_JALR: ADD rs1+imm, pc_write=1, pc_sel=2, reg_write=1, wb_sel=2; retire.
- S_UPPER: LUI uses src_a=2; AUIPC uses src_a=1. Both use src_b=1 and ADD; go to S_WB_ALU.
- Memory timeout:
  - The wait counter increments each cycle mem_req=1 && !mem_ready, and clears on any state change.
  - When it reaches MEM_TIMEOUT, go to S_TRAP with cause 2 the next cycle.
  - mem_ready on the same cycle the counter hits the limit wins; no trap.
- S_TRAP:
  - trap=1 and trap_cause hold until reset.
  - No strobes are asserted.
  - cycle_count keeps counting.
- Counters:
  - cycle_count increments every cycle outside S_HALT.
  - instret_count increments on the retire cycle only.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Shared package rv32i_pkg holds:
  - alu_op_t encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - opcode_t constants.
  - mc_state_t enum.
  - pc_sel_t, wb_sel_t and trap_cause_t enums.
- Sub-module: rv32i_alu_decode, a combinational mapping of {latched opcode class, func3, func7} to alu_ctrl. It is reused by the future pipelined core.

Test Plan:
- ADD: opcode 0110011, func3 000, func7 0, mem_ready on the first cycle -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write is high in the 4th cycle; instret_count = 1, cycle_count = 4.
- LW with 3 wait states per access -> mem_req held 4 cycles in FETCH and 4 in MEM_RD; wb_sel=1; 11 cycles per instruction; no trap.
- Branches:
  - BNE with zero=0 -> pc_write=1, pc_sel=1 in S_BRANCH.
  - BGEU with less_u=1 -> pc_write stays 0.
  - func3 011 -> trap=1, trap_cause=1.
- Timeout, MEM_TIMEOUT=16:
  - mem_ready held low in FETCH -> S_TRAP entered the cycle after 16 waiting cycles, trap_cause=2, mem_req drops to 0.
  - Repeat with mem_ready arriving exactly on the 16th waiting cycle -> no trap.
- Illegal opcode 1111111 -> trap=1, trap_cause=1; afterwards no strobes; cycle_count keeps counting, instret_count frozen.
- Async reset asserted mid S_MEM_WR -> all strobes 0 within the same cycle; counters 0; S_FETCH entered after deassertion. Also CNT_W=4: after 16 cycles cycle_count wraps to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared type and constant definitions for the RV32I cores: ALU operation
// encodings, major opcodes, the multi-cycle controller state set, and the
// enumerations used for the PC, writeback and trap-cause selects.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_pkg;

    // ALU operation encodings, shared with the data_path ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // How the ALU decoder should interpret func3/func7 in a given state.
    typedef enum logic [1:0] {
        ALU_CLASS_ADD = 2'd0,
        ALU_CLASS_SUB = 2'd1,
        ALU_CLASS_R   = 2'd2,
        ALU_CLASS_I   = 2'd3
    } alu_class_t;

    // Major opcodes (IR[6:0]).
    typedef logic [6:0] opcode_t;
    localparam opcode_t OP_R_TYPE = 7'b0110011;
    localparam opcode_t OP_I_ALU  = 7'b0010011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;

    // Multi-cycle controller states.
    typedef enum logic [3:0] {
        S_HALT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_UPPER  = 4'd13,
        S_TRAP   = 4'd14
    } mc_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        TRAP_NONE        = 2'd0,
        TRAP_ILLEGAL     = 2'd1,
        TRAP_MEM_TIMEOUT = 2'd2
    } trap_cause_t;

    // ALU operand select encodings.
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/rv32i_alu_decode.sv
// ---------------------------------------------------------------------------
// rv32i_alu_decode
// Combinational mapping of {opcode class, func3, func7} to an ALU operation.
// Ports:
//   alu_class : forced ADD / forced SUB / R-type / I-type interpretation
//   func3     : IR[14:12]
//   func7     : IR[30]
//   alu_ctrl  : resulting ALU operation
// ---------------------------------------------------------------------------
module rv32i_alu_decode
    import rv32i_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] func3,
    input  logic       func7,
    output alu_op_t    alu_ctrl
);

    // IR[30] only distinguishes SUB (R-type) and SRA/SRAI; for ADDI it is
    // part of the immediate and must be ignored.
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (alu_class == ALU_CLASS_SUB) begin
            alu_ctrl = ALU_SUB;
        end else if (alu_class == ALU_CLASS_R || alu_class == ALU_CLASS_I) begin
            case (func3)
                3'b000: begin
                    if (alu_class == ALU_CLASS_R && func7) alu_ctrl = ALU_SUB;
                    else                                    alu_ctrl = ALU_ADD;
                end
                3'b001: alu_ctrl = ALU_SLL;
                3'b010: alu_ctrl = ALU_SLT;
                3'b011: alu_ctrl = ALU_SLTU;
                3'b100: alu_ctrl = ALU_XOR;
                3'b101: begin
                    if (func7) alu_ctrl = ALU_SRA;
                    else       alu_ctrl = ALU_SRL;
                end
                3'b110: alu_ctrl = ALU_OR;
                3'b111: alu_ctrl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_mc_control.sv
// ---------------------------------------------------------------------------
// rv32i_mc_control
// Multi-cycle control unit for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback through a shared memory port with a
// req/ready handshake, traps on illegal instructions and memory timeouts,
// and keeps cycle / retired-instruction counters.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : leaves S_HALT (RESET_TO_FETCH = 0 only)
//   opcode/func3/func7  : instruction register fields
//   zero/less/less_u    : ALU comparison flags for branches
//   mem_ready           : memory completes the current request this cycle
//   mem_req/mem_we      : memory request valid / request is a write
//   addr_sel            : memory address select (0 PC, 1 ALU result reg)
//   ir_write, pc_write  : IR latch / PC update strobes
//   pc_sel              : PC source (PC+4, target, JALR)
//   alu_src_a/b, alu_ctrl : ALU operand selects and operation
//   reg_write, wb_sel   : register file write enable and writeback source
//   trap, trap_cause    : sticky fault flag and cause
//   cycle_count, instret_count : performance counters (wrap on overflow)
// ---------------------------------------------------------------------------
module rv32i_mc_control
    import rv32i_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int MEM_TIMEOUT    = 16,
    parameter bit RESET_TO_FETCH = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             less,
    input  logic             less_u,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    mc_state_t         state;
    mc_state_t         next_state;
    trap_cause_t       next_cause;
    trap_cause_t       cause_q;
    logic [6:0]        op_q;
    logic [2:0]        func3_q;
    logic              func7_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              timeout_hit;
    logic              branch_taken;
    logic              branch_illegal;
    alu_class_t        alu_class;
    alu_op_t           alu_op;

    rv32i_alu_decode u_alu_decode (
        .alu_class (alu_class),
        .func3     (func3_q),
        .func7     (func7_q),
        .alu_ctrl  (alu_op)
    );

    assign alu_ctrl   = alu_op;
    assign trap_cause = cause_q;

    // The request has been waiting WAIT_LIMIT cycles already and is still
    // unanswered this cycle; a ready arriving now takes priority.
    assign timeout_hit = mem_req && !mem_ready && (wait_cnt == WAIT_LIMIT);

    assign branch_illegal = (func3_q == 3'b010) || (func3_q == 3'b011);

    // Branch condition from the latched func3; reserved encodings never take.
    always_comb begin
        branch_taken = 1'b0;
        case (func3_q)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = less;
            3'b101:  branch_taken = !less;
            3'b110:  branch_taken = less_u;
            3'b111:  branch_taken = !less_u;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state, trap cause and retirement decode. Decode uses the live IR
    // fields because the IR was written on the fetch-completion edge; every
    // later state uses the copies latched while leaving S_DECODE.
    always_comb begin
        next_state = state;
        next_cause = TRAP_NONE;
        retire     = 1'b0;
        case (state)
            S_HALT: if (start) next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_MEM_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R_TYPE:          next_state = S_EXEC_R;
                    OP_I_ALU:           next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_JALR:            next_state = S_JALR;
                    OP_LUI, OP_AUIPC:   next_state = S_UPPER;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
            S_ADDR: begin
                if (op_q == OP_LOAD) next_state = S_MEM_RD;
                else                 next_state = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    next_state = S_WB_MEM;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_MEM_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_MEM_TIMEOUT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_JAL, S_JALR: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                if (branch_illegal) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_ILLEGAL;
                end else begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_UPPER: next_state = S_WB_ALU;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
    end

    // Moore output decode. Holding reset forces every strobe and select to
    // zero at once, even though the state register already shows S_FETCH.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_class = ALU_CLASS_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                end
                S_EXEC_R: alu_class = ALU_CLASS_R;
                S_EXEC_I: begin
                    alu_class = ALU_CLASS_I;
                    alu_src_b = SRC_B_IMM;
                end
                S_ADDR: alu_src_b = SRC_B_IMM;
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MEM;
                end
                S_BRANCH: begin
                    alu_class = ALU_CLASS_SUB;
                    if (branch_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_TARGET;
                    end
                end
                S_JAL: begin
                    pc_write  = 1'b1;
                    pc_sel    = PC_TARGET;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                end
                S_JALR: begin
                    alu_src_b = SRC_B_IMM;
                    pc_write  = 1'b1;
                    pc_sel    = PC_JALR;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                end
                S_UPPER: begin
                    alu_src_a = (op_q == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                end
                default: ;
            endcase
        end
    end

    // State register plus everything that must survive across cycles: the
    // latched IR fields, the memory wait counter, the sticky trap and the
    // performance counters. The wait counter restarts on every state change
    // so each memory access gets its own timeout window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (RESET_TO_FETCH) state <= S_FETCH;
            else                state <= S_HALT;
            op_q          <= '0;
            func3_q       <= '0;
            func7_q       <= 1'b0;
            wait_cnt      <= '0;
            trap          <= 1'b0;
            cause_q       <= TRAP_NONE;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state != S_HALT) cycle_count <= cycle_count + CNT_W'(1);
            if (retire) instret_count <= instret_count + CNT_W'(1);
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state == S_DECODE) begin
                op_q    <= opcode;
                func3_q <= func3;
                func7_q <= func7;
            end
            if (next_state == S_TRAP && state != S_TRAP) begin
                trap    <= 1'b1;
                cause_q <= next_cause;
            end
            state <= next_state;
        end
    end

endmodule

// File: tb/tb_rv32i_mc_control.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mc_control
// Self-checking bench for rv32i_mc_control: a table of single instructions
// run with zero wait states, plus hand-written sequences for wait states,
// memory timeout, illegal opcode trapping, async reset and counter wrap.
// ---------------------------------------------------------------------------
module tb_rv32i_mc_control;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic        zero;
    logic        less;
    logic        less_u;
    logic        mem_ready;

    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, trap;
    logic [1:0]  pc_sel, alu_src_a, alu_src_b, wb_sel, trap_cause;
    logic [3:0]  alu_ctrl;
    logic [31:0] cycle_count, instret_count;

    logic        w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write, w_reg_write, w_trap;
    logic [1:0]  w_pc_sel, w_alu_src_a, w_alu_src_b, w_wb_sel, w_trap_cause;
    logic [3:0]  w_alu_ctrl;
    logic [3:0]  w_cycle_count, w_instret_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic       func7;
        logic       zero;
        logic       less;
        logic       less_u;
        logic [3:0] alu;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       reg_write;
        logic [1:0] wb_sel;
        int         edges;
        int         retired;
        logic       trap;
        logic [1:0] cause;
    } vec_t;

    vec_t vec_list[$];
    vec_t exp_q[$];

    rv32i_mc_control dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .zero          (zero),
        .less          (less),
        .less_u        (less_u),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    rv32i_mc_control #(.CNT_W(4)) dut_w (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .zero          (zero),
        .less          (less),
        .less_u        (less_u),
        .mem_ready     (mem_ready),
        .mem_req       (w_mem_req),
        .mem_we        (w_mem_we),
        .addr_sel      (w_addr_sel),
        .ir_write      (w_ir_write),
        .pc_write      (w_pc_write),
        .pc_sel        (w_pc_sel),
        .alu_src_a     (w_alu_src_a),
        .alu_src_b     (w_alu_src_b),
        .alu_ctrl      (w_alu_ctrl),
        .reg_write     (w_reg_write),
        .wb_sel        (w_wb_sel),
        .trap          (w_trap),
        .trap_cause    (w_trap_cause),
        .cycle_count   (w_cycle_count),
        .instret_count (w_instret_count)
    );

    // 10 ns clock; inputs change and outputs are sampled just after negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence ever stalls the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready);
        mem_ready = ready;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point of the first cycle after reset.
    task automatic applyReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic addVec(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic z, input logic l, input logic lu,
                          input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                          input logic pcw, input logic [1:0] pcs, input logic rw,
                          input logic [1:0] wb, input int edges, input int ret,
                          input logic tr, input logic [1:0] cause);
        vec_t v;
        v.name = name;     v.opcode = op;    v.func3 = f3;     v.func7 = f7;
        v.zero = z;        v.less = l;       v.less_u = lu;    v.alu = alu;
        v.src_a = sa;      v.src_b = sb;     v.pc_write = pcw; v.pc_sel = pcs;
        v.reg_write = rw;  v.wb_sel = wb;    v.edges = edges;  v.retired = ret;
        v.trap = tr;       v.cause = cause;
        vec_list.push_back(v);
    endtask

    // One instruction with zero wait states: the expected record goes onto
    // the scoreboard when the inputs are driven and is compared against the
    // third cycle (execute / branch / jump / trap state) and the final counts.
    task automatic runVector(input vec_t v);
        vec_t e;
        opcode    = v.opcode;
        func3     = v.func3;
        func7     = v.func7;
        zero      = v.zero;
        less      = v.less;
        less_u    = v.less_u;
        mem_ready = 1'b1;
        exp_q.push_back(v);
        applyReset();
        nextCycle();
        nextCycle();
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected one record", v.name);
        end else begin
            e = exp_q.pop_front();
            checkOutput({e.name, " alu_ctrl"},  alu_ctrl,  e.alu);
            checkOutput({e.name, " alu_src_a"}, alu_src_a, e.src_a);
            checkOutput({e.name, " alu_src_b"}, alu_src_b, e.src_b);
            checkOutput({e.name, " pc_write"},  pc_write,  e.pc_write);
            checkOutput({e.name, " pc_sel"},    pc_sel,    e.pc_sel);
            checkOutput({e.name, " reg_write"}, reg_write, e.reg_write);
            checkOutput({e.name, " wb_sel"},    wb_sel,    e.wb_sel);
            repeat (e.edges - 2) nextCycle();
            checkOutput({e.name, " cycle_count"},   cycle_count,   e.edges);
            checkOutput({e.name, " instret_count"}, instret_count, e.retired);
            checkOutput({e.name, " trap"},          trap,          e.trap);
            checkOutput({e.name, " trap_cause"},    trap_cause,    e.cause);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 7'b0; func3 = 3'b0; func7 = 1'b0;
        zero = 1'b0; less = 1'b0; less_u = 1'b0; mem_ready = 1'b0;

        //      name      opcode     f3      f7 z  l  lu  alu sa sb pcw pcs rw wb  n  ret tr cause
        addVec("add",    OP_R_TYPE, 3'b000, 1, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        vec_list[0].func7 = 1'b0; vec_list[0].alu = 4'd0;
        addVec("sub",    OP_R_TYPE, 3'b000, 1, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("sra",    OP_R_TYPE, 3'b101, 1, 0, 0, 0,   7, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("srl",    OP_R_TYPE, 3'b101, 0, 0, 0, 0,   6, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("sltu",   OP_R_TYPE, 3'b011, 0, 0, 0, 0,   4, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("or",     OP_R_TYPE, 3'b110, 0, 0, 0, 0,   8, 0, 0, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("addi7",  OP_I_ALU,  3'b000, 1, 0, 0, 0,   0, 0, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("srai",   OP_I_ALU,  3'b101, 1, 0, 0, 0,   7, 0, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("xori",   OP_I_ALU,  3'b100, 0, 0, 0, 0,   5, 0, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("andi",   OP_I_ALU,  3'b111, 0, 0, 0, 0,   9, 0, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("bne_nz", OP_BRANCH, 3'b001, 0, 0, 0, 0,   1, 0, 0, 1,  1,  0, 0, 3, 1,  0, 0);
        addVec("beq_nz", OP_BRANCH, 3'b000, 0, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 3, 1,  0, 0);
        addVec("bgeu_l", OP_BRANCH, 3'b111, 0, 0, 0, 1,   1, 0, 0, 0,  0,  0, 0, 3, 1,  0, 0);
        addVec("blt_l",  OP_BRANCH, 3'b100, 0, 0, 1, 0,   1, 0, 0, 1,  1,  0, 0, 3, 1,  0, 0);
        addVec("bge_l",  OP_BRANCH, 3'b101, 0, 0, 1, 0,   1, 0, 0, 0,  0,  0, 0, 3, 1,  0, 0);
        addVec("br011",  OP_BRANCH, 3'b011, 0, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 3, 0,  1, 1);
        addVec("jal",    OP_JAL,    3'b000, 0, 0, 0, 0,   0, 0, 0, 1,  1,  1, 2, 3, 1,  0, 0);
        addVec("jalr",   OP_JALR,   3'b000, 0, 0, 0, 0,   0, 0, 1, 1,  2,  1, 2, 3, 1,  0, 0);
        addVec("lui",    OP_LUI,    3'b000, 0, 0, 0, 0,   0, 2, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("auipc",  OP_AUIPC,  3'b000, 0, 0, 0, 0,   0, 1, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("lw",     OP_LOAD,   3'b010, 0, 0, 0, 0,   0, 0, 1, 0,  0,  0, 0, 5, 1,  0, 0);
        addVec("sw",     OP_STORE,  3'b010, 0, 0, 0, 0,   0, 0, 1, 0,  0,  0, 0, 4, 1,  0, 0);
        addVec("illegal",7'h7F,     3'b000, 0, 0, 0, 0,   0, 0, 0, 0,  0,  0, 0, 2, 0,  1, 1);

        for (int i = 0; i < vec_list.size(); i++) runVector(vec_list[i]);

        // ADD walk-through: fetch strobes, decode selects, writeback cycle.
        opcode = OP_R_TYPE; func3 = 3'b000; func7 = 1'b0; mem_ready = 1'b1;
        applyReset();
        checkOutput("reset fetch mem_req",  mem_req,  1'b1);
        checkOutput("reset fetch addr_sel", addr_sel, 1'b0);
        checkOutput("reset cycle_count",    cycle_count, 0);
        checkOutput("reset trap",           trap,     1'b0);
        checkOutput("add c1 ir_write",  ir_write,  1'b1);
        checkOutput("add c1 pc_write",  pc_write,  1'b1);
        checkOutput("add c1 pc_sel",    pc_sel,    2'd0);
        checkOutput("add c1 alu_src_a", alu_src_a, 2'd1);
        checkOutput("add c1 alu_src_b", alu_src_b, 2'd2);
        nextCycle();
        checkOutput("add c2 mem_req",   mem_req,   1'b0);
        checkOutput("add c2 alu_src_a", alu_src_a, 2'd1);
        checkOutput("add c2 alu_src_b", alu_src_b, 2'd1);
        nextCycle();
        nextCycle();
        checkOutput("add c4 reg_write", reg_write, 1'b1);
        checkOutput("add c4 wb_sel",    wb_sel,    2'd0);

        // LW with three wait states on both the fetch and the data read.
        opcode = OP_LOAD; func3 = 3'b010; mem_ready = 1'b0;
        applyReset();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) nextCycle();
            applyStimulus(!((c <= 3) || (c >= 7 && c <= 9)));
            checkOutput($sformatf("lw c%0d mem_req", c),   mem_req,   (c <= 4) || (c >= 7 && c <= 10));
            checkOutput($sformatf("lw c%0d addr_sel", c),  addr_sel,  (c >= 7 && c <= 10));
            checkOutput($sformatf("lw c%0d ir_write", c),  ir_write,  (c == 4));
            checkOutput($sformatf("lw c%0d reg_write", c), reg_write, (c == 11));
            checkOutput($sformatf("lw c%0d wb_sel", c),    wb_sel,    (c == 11) ? 2'd1 : 2'd0);
        end
        nextCycle();
        checkOutput("lw cycle_count",   cycle_count,   11);
        checkOutput("lw instret_count", instret_count, 1);
        checkOutput("lw trap",          trap,          1'b0);

        // Fetch never answered: trap after 16 waiting cycles.
        opcode = OP_R_TYPE; mem_ready = 1'b0;
        applyReset();
        repeat (15) nextCycle();
        checkOutput("timeout c16 mem_req", mem_req, 1'b1);
        checkOutput("timeout c16 trap",    trap,    1'b0);
        nextCycle();
        checkOutput("timeout trap",       trap,       1'b1);
        checkOutput("timeout trap_cause", trap_cause, 2'd2);
        checkOutput("timeout mem_req",    mem_req,    1'b0);

        // Ready on the 16th waiting cycle completes the fetch instead.
        mem_ready = 1'b0;
        applyReset();
        repeat (15) nextCycle();
        applyStimulus(1'b1);
        checkOutput("late ready ir_write", ir_write, 1'b1);
        nextCycle();
        checkOutput("late ready trap",      trap,      1'b0);
        checkOutput("late ready decode a",  alu_src_a, 2'd1);
        checkOutput("late ready mem_req",   mem_req,   1'b0);

        // Illegal opcode: trap is sticky, strobes idle, cycles keep counting.
        opcode = 7'h7F; mem_ready = 1'b1;
        applyReset();
        nextCycle();
        nextCycle();
        repeat (5) nextCycle();
        checkOutput("ill cycle_count",   cycle_count,   7);
        checkOutput("ill instret_count", instret_count, 0);
        checkOutput("ill trap",          trap,          1'b1);
        checkOutput("ill trap_cause",    trap_cause,    2'd1);
        checkOutput("ill mem_req",       mem_req,       1'b0);
        checkOutput("ill ir_write",      ir_write,      1'b0);
        checkOutput("ill pc_write",      pc_write,      1'b0);
        checkOutput("ill reg_write",     reg_write,     1'b0);

        // Async reset while a store is waiting on memory.
        opcode = OP_STORE; func3 = 3'b010; mem_ready = 1'b1;
        applyReset();
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b0);
        checkOutput("sw c4 mem_we",  mem_we,  1'b1);
        checkOutput("sw c4 mem_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid reset mem_req",       mem_req,       1'b0);
        checkOutput("mid reset mem_we",        mem_we,        1'b0);
        checkOutput("mid reset addr_sel",      addr_sel,      1'b0);
        checkOutput("mid reset alu_src_a",     alu_src_a,     2'd0);
        checkOutput("mid reset cycle_count",   cycle_count,   0);
        checkOutput("mid reset instret_count", instret_count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post reset fetch mem_req",  mem_req,  1'b1);
        checkOutput("post reset fetch addr_sel", addr_sel, 1'b0);
        checkOutput("post reset mem_we",         mem_we,   1'b0);

        // Four back-to-back ADDs: 16 cycles wraps the 4-bit counter.
        opcode = OP_R_TYPE; func3 = 3'b000; func7 = 1'b0; mem_ready = 1'b1;
        applyReset();
        repeat (16) nextCycle();
        checkOutput("wrap cnt32 cycle_count", cycle_count,     16);
        checkOutput("wrap cnt4 cycle_count",  w_cycle_count,   4'd0);
        checkOutput("wrap cnt4 instret",      w_instret_count, 4'd4);
        checkOutput("wrap cnt32 instret",     instret_count,   4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
